wb_slave_mux: RTL and testbench



---
 rtl/wb_slave_mux_if.sv | 44 ++++
 rtl/wb_slave_mux.sv | 186 ++++++++++++++++++
 tb/tb_wb_slave_mux.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_mux_if.sv
// rtl/wb_slave_mux_if.sv - bus bundle between the bridge, the decoder and its slaves
interface wb_slave_mux_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_SLAVES = 4
);
   logic                             wbs_cyc_i;
   logic                             wbs_stb_i;
   logic                             wbs_we_i;
   logic [3:0]                       wbs_sel_i;
   logic [ADDR_WIDTH-1:0]            wbs_adr_i;
   logic [DATA_WIDTH-1:0]            wbs_dat_i;
   logic [DATA_WIDTH-1:0]            wbs_dat_o;
   logic                             wbs_ack_o;
   logic                             wbs_err_o;
   logic [NUM_SLAVES-1:0]            wbm_cyc_o;
   logic [NUM_SLAVES-1:0]            wbm_stb_o;
   logic                             wbm_we_o;
   logic [3:0]                       wbm_sel_o;
   logic [ADDR_WIDTH-1:0]            wbm_adr_o;
   logic [DATA_WIDTH-1:0]            wbm_dat_o;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] wbm_dat_i;
   logic [NUM_SLAVES-1:0]            wbm_ack_i;
   logic [NUM_SLAVES-1:0]            wbm_err_i;
   logic                             busy_o;
   logic                             timeout_o;
   logic                             dropped_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o, wbs_err_o,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i, wbm_err_i,
      output busy_o, timeout_o, dropped_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o, wbs_err_o,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i, wbm_err_i,
      input  busy_o, timeout_o, dropped_o
   );
endinterface

// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - single-master Wishbone decoder holding one request until a slave answers or the watchdog fires
module wb_slave_mux #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEC_LSB    = 20,
   parameter int DEC_BITS   = 2,
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   wb_slave_mux_if.slave bus
);
   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DEC_BITS-1:0]   idx_q, idx_d;
   logic [NUM_SLAVES-1:0] cyc_q, cyc_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
   logic                  we_q, we_d;
   logic [3:0]            sel_q, sel_d;
   logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic                  timeout_q, timeout_d;
   logic                  dropped_q, dropped_d;

   logic                  req;
   logic [DEC_BITS-1:0]   req_idx;
   logic                  req_valid;
   logic [NUM_SLAVES-1:0] req_onehot;
   logic                  slv_ack;
   logic                  slv_err;
   logic [DATA_WIDTH-1:0] slv_dat;
   logic                  wdog_hit;

   assign req       = bus.wbs_cyc_i & bus.wbs_stb_i;
   assign req_idx   = bus.wbs_adr_i[DEC_LSB +: DEC_BITS];
   assign req_valid = int'(req_idx) < NUM_SLAVES;
   assign wdog_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      req_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         req_onehot[i] = (req_idx == DEC_BITS'(i));
      end
   end

   // Only the slave latched at request time may end the cycle; others are ignored.
   always_comb begin
      slv_ack = 1'b0;
      slv_err = 1'b0;
      slv_dat = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == DEC_BITS'(i)) begin
            slv_ack = bus.wbm_ack_i[i];
            slv_err = bus.wbm_err_i[i];
            slv_dat = bus.wbm_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      cyc_d     = cyc_q;
      adr_d     = adr_q;
      wdat_d    = wdat_q;
      we_d      = we_q;
      sel_d     = sel_q;
      rdat_d    = rdat_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      timeout_d = 1'b0;
      dropped_d = req & (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (req) begin
               adr_d  = bus.wbs_adr_i;
               wdat_d = bus.wbs_dat_i;
               we_d   = bus.wbs_we_i;
               sel_d  = bus.wbs_sel_i;
               idx_d  = req_idx;
               if (req_valid) begin
                  state_d = ACTIVE;
                  cnt_d   = '0;
                  cyc_d   = req_onehot;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdat_d  = '0;
               end
            end
         end
         ACTIVE: begin
            if (slv_err) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdat_d  = slv_dat;
               cyc_d   = '0;
            end else if (slv_ack) begin
               state_d = RESP;
               ack_d   = 1'b1;
               rdat_d  = slv_dat;
               cyc_d   = '0;
            end else if (wdog_hit) begin
               state_d   = RESP;
               err_d     = 1'b1;
               rdat_d    = '0;
               timeout_d = 1'b1;
               cyc_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         cyc_q     <= '0;
         adr_q     <= '0;
         wdat_q    <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         rdat_q    <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         cyc_q     <= cyc_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         rdat_q    <= rdat_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         dropped_q <= dropped_d;
      end
   end

   assign bus.wbs_dat_o = rdat_q;
   assign bus.wbs_ack_o = ack_q;
   assign bus.wbs_err_o = err_q;
   assign bus.wbm_cyc_o = cyc_q;
   assign bus.wbm_stb_o = cyc_q;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = sel_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = wdat_q;
   assign bus.busy_o    = busy_q;
   assign bus.timeout_o = timeout_q;
   assign bus.dropped_o = dropped_q;
endmodule

// File: tb/tb_wb_slave_mux.sv
// tb/tb_wb_slave_mux.sv - randomized and directed bench for wb_slave_mux against a transaction-level model
module tb_wb_slave_mux;
   localparam int NS = 3;
   localparam int TO = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_slave_mux_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .NUM_SLAVES(NS)) bus ();

   wb_slave_mux #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(32), .DEC_LSB(20), .DEC_BITS(2),
      .NUM_SLAVES(NS), .TIMEOUT(TO)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int          o_resp, o_nack, o_nerr, o_nto, o_to_cyc, o_ncyc, o_nboth;
   int          o_ndrop, o_drop_cyc, o_shared_bad, o_stb_bad;
   logic [NS-1:0] o_cyc_or;
   logic [31:0] o_dat;
   logic        o_busy_resp, o_busy_after;

   int          e_resp, e_ncyc;
   logic        e_ack, e_err, e_to;
   logic [31:0] e_dat;
   logic [NS-1:0] e_cyc_or;

   // kind: 0 ack, 1 err, 2 ack+err, 3 never answers; d = cycle of the slave's answer
   task automatic model(input int idx, input int d, input int kind, input logic [31:0] rd);
      e_cyc_or = '0;
      if (idx >= NS) begin
         e_resp = 1; e_ack = 1'b0; e_err = 1'b1; e_to = 1'b0; e_dat = '0; e_ncyc = 0;
      end else begin
         e_cyc_or[idx] = 1'b1;
         if (kind != 3 && d <= TO) begin
            e_resp = d + 1; e_ack = (kind == 0); e_err = (kind != 0); e_to = 1'b0; e_dat = rd;
         end else begin
            e_resp = TO + 1; e_ack = 1'b0; e_err = 1'b1; e_to = 1'b1; e_dat = '0;
         end
         e_ncyc = e_resp - 1;
      end
   endtask

   task automatic clear_inputs();
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
      bus.wbm_dat_i = '0;   bus.wbm_ack_i = '0;   bus.wbm_err_i = '0;
   endtask

   // Drives one request and plays the slaves; called at #1 into an idle cycle, returns at #1 into the cycle after RESP.
   task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                          input logic [3:0] sel, input int d, input int kind,
                          input logic [31:0] rd, input int drop_at);
      int idx;
      idx = int'(adr[21:20]);
      o_resp = 0; o_nack = 0; o_nerr = 0; o_nto = 0; o_to_cyc = 0; o_ncyc = 0; o_nboth = 0;
      o_ndrop = 0; o_drop_cyc = 0; o_shared_bad = 0; o_stb_bad = 0; o_cyc_or = '0;
      o_dat = 'x; o_busy_resp = 1'b0; o_busy_after = 1'bx;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
      bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = wd;
      for (int c = 1; c <= TO + 6; c++) begin
         @(posedge clk); #1;
         bus.wbs_cyc_i = (c == drop_at);
         bus.wbs_stb_i = (c == drop_at);
         bus.wbs_adr_i = $urandom;
         bus.wbs_dat_i = $urandom;
         bus.wbs_we_i  = ~we;
         if (bus.wbm_cyc_o != '0) begin
            o_ncyc++;
            o_cyc_or = o_cyc_or | bus.wbm_cyc_o;
            if (bus.wbm_adr_o !== adr || bus.wbm_dat_o !== wd || bus.wbm_we_o !== we || bus.wbm_sel_o !== sel)
               o_shared_bad++;
         end
         if (bus.wbm_stb_o !== bus.wbm_cyc_o) o_stb_bad++;
         if (bus.wbs_ack_o && bus.wbs_err_o) o_nboth++;
         if (bus.wbs_ack_o) o_nack++;
         if (bus.wbs_err_o) o_nerr++;
         if ((bus.wbs_ack_o || bus.wbs_err_o) && o_resp == 0) begin
            o_resp = c; o_dat = bus.wbs_dat_o; o_busy_resp = bus.busy_o;
         end
         if (bus.timeout_o) begin o_nto++; o_to_cyc = c; end
         if (bus.dropped_o) begin o_ndrop++; o_drop_cyc = c; end
         for (int i = 0; i < NS; i++) begin
            bus.wbm_dat_i[i*DW +: DW] = $urandom;
            if (i == idx) begin
               bus.wbm_ack_i[i] = (c == d) && (kind == 0 || kind == 2);
               bus.wbm_err_i[i] = (c == d) && (kind == 1 || kind == 2);
               bus.wbm_dat_i[i*DW +: DW] = rd;
            end else begin
               bus.wbm_ack_i[i] = 1'($urandom % 2);
               bus.wbm_err_i[i] = 1'($urandom % 2);
            end
         end
         if (o_resp != 0 && c == o_resp + 1) begin
            o_busy_after = bus.busy_o;
            bus.wbs_we_i = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbs_ack_o, bus.wbs_err_o, bus.busy_o, bus.timeout_o, bus.dropped_o} !== '0) begin
         n_fail++; $display("FAIL reset_flags got cyc=%b stb=%b ack=%b err=%b busy=%b to=%b drop=%b want all 0",
            bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbs_ack_o, bus.wbs_err_o, bus.busy_o, bus.timeout_o, bus.dropped_o);
      end
      n_checks++;
      if ({bus.wbs_dat_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_we_o, bus.wbm_sel_o} !== '0) begin
         n_fail++; $display("FAIL reset_data got dat_o=%h adr=%h wdat=%h we=%b sel=%b want 0",
            bus.wbs_dat_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_we_o, bus.wbm_sel_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_read_slave1();
      run_txn(32'h0010_0040, 1'b0, 32'h0, 4'hF, 3, 0, 32'hCAFE_F00D, 0);
      n_checks++;
      if (o_ncyc !== 3 || o_cyc_or !== 3'b010) begin
         n_fail++; $display("FAIL read1_cyc got %0d cycles mask %b want 3 cycles mask 010", o_ncyc, o_cyc_or);
      end
      n_checks++;
      if (o_resp !== 4 || o_nack !== 1 || o_nerr !== 0) begin
         n_fail++; $display("FAIL read1_ack got resp_cycle=%0d acks=%0d errs=%0d want 4/1/0", o_resp, o_nack, o_nerr);
      end
      n_checks++;
      if (o_dat !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL read1_data got %h want cafef00d", o_dat);
      end
      n_checks++;
      if (o_busy_resp !== 1'b1 || o_busy_after !== 1'b0) begin
         n_fail++; $display("FAIL read1_busy got resp=%b after=%b want 1/0", o_busy_resp, o_busy_after);
      end
   endtask

   task automatic test_write_slave0();
      run_txn(32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0011, 2, 0, 32'h0BAD_0001, 0);
      n_checks++;
      if (o_ncyc !== 2 || o_cyc_or !== 3'b001 || o_shared_bad !== 0 || o_stb_bad !== 0) begin
         n_fail++; $display("FAIL write0_hold got cycles=%0d mask=%b shared_bad=%0d stb_bad=%0d want 2/001/0/0",
            o_ncyc, o_cyc_or, o_shared_bad, o_stb_bad);
      end
      n_checks++;
      if (o_nack !== 1 || o_nerr !== 0 || o_resp !== 3 || o_dat !== 32'h0BAD_0001) begin
         n_fail++; $display("FAIL write0_ack got acks=%0d errs=%0d resp_cycle=%0d dat=%h want 1/0/3/0bad0001",
            o_nack, o_nerr, o_resp, o_dat);
      end
   endtask

   task automatic test_watchdog();
      run_txn(32'h0020_0000, 1'b0, 32'h0, 4'hF, 0, 3, 32'hFFFF_FFFF, 0);
      n_checks++;
      if (o_ncyc !== TO || o_cyc_or !== 3'b100) begin
         n_fail++; $display("FAIL wdog_cyc got %0d cycles mask %b want %0d mask 100", o_ncyc, o_cyc_or, TO);
      end
      n_checks++;
      if (o_resp !== TO + 1 || o_nerr !== 1 || o_nack !== 0 || o_nto !== 1 || o_to_cyc !== TO + 1) begin
         n_fail++; $display("FAIL wdog_err got resp=%0d errs=%0d acks=%0d to=%0d to_cyc=%0d want %0d/1/0/1/%0d",
            o_resp, o_nerr, o_nack, o_nto, o_to_cyc, TO + 1, TO + 1);
      end
      n_checks++;
      if (o_dat !== 32'h0) begin
         n_fail++; $display("FAIL wdog_data got %h want 0", o_dat);
      end
   endtask

   task automatic test_ack_final_edge();
      run_txn(32'h0010_0000, 1'b0, 32'h0, 4'hF, TO, 0, 32'h5A5A_1234, 0);
      n_checks++;
      if (o_nack !== 1 || o_nerr !== 0 || o_nto !== 0 || o_resp !== TO + 1 || o_dat !== 32'h5A5A_1234) begin
         n_fail++; $display("FAIL final_edge got acks=%0d errs=%0d to=%0d resp=%0d dat=%h want 1/0/0/%0d/5a5a1234",
            o_nack, o_nerr, o_nto, o_resp, o_dat, TO + 1);
      end
   endtask

   task automatic test_invalid_index();
      run_txn(32'h0030_0000, 1'b0, 32'h0, 4'hF, 1, 0, 32'h7777_7777, 0);
      n_checks++;
      if (o_ncyc !== 0 || o_resp !== 1 || o_nerr !== 1 || o_nack !== 0 || o_nto !== 0 || o_dat !== 32'h0) begin
         n_fail++; $display("FAIL invalid_idx got cycles=%0d resp=%0d errs=%0d acks=%0d to=%0d dat=%h want 0/1/1/0/0/0",
            o_ncyc, o_resp, o_nerr, o_nack, o_nto, o_dat);
      end
   endtask

   task automatic test_ack_and_err();
      run_txn(32'h0020_0010, 1'b0, 32'h0, 4'hF, 2, 2, 32'hDEAD_BEEF, 0);
      n_checks++;
      if (o_nerr !== 1 || o_nack !== 0 || o_nboth !== 0 || o_resp !== 3 || o_dat !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL ack_err got errs=%0d acks=%0d both=%0d resp=%0d dat=%h want 1/0/0/3/deadbeef",
            o_nerr, o_nack, o_nboth, o_resp, o_dat);
      end
   endtask

   task automatic test_dropped();
      run_txn(32'h0010_0008, 1'b1, 32'hA1B2_C3D4, 4'b1000, 4, 0, 32'h0000_1111, 2);
      n_checks++;
      if (o_ndrop !== 1 || o_drop_cyc !== 3) begin
         n_fail++; $display("FAIL dropped_pulse got count=%0d cycle=%0d want 1/3", o_ndrop, o_drop_cyc);
      end
      n_checks++;
      if (o_ncyc !== 4 || o_shared_bad !== 0 || o_nack !== 1 || o_resp !== 5 || o_dat !== 32'h0000_1111) begin
         n_fail++; $display("FAIL dropped_first got cycles=%0d shared_bad=%0d acks=%0d resp=%0d dat=%h want 4/0/1/5/00001111",
            o_ncyc, o_shared_bad, o_nack, o_resp, o_dat);
      end
   endtask

   task automatic test_back_to_back();
      run_txn(32'h0000_0004, 1'b0, 32'h0, 4'hF, 1, 0, 32'h1111_0000, 0);
      run_txn(32'h0020_0004, 1'b0, 32'h0, 4'hF, 1, 0, 32'h2222_0000, 0);
      n_checks++;
      if (o_resp !== 2 || o_nack !== 1 || o_dat !== 32'h2222_0000 || o_cyc_or !== 3'b100) begin
         n_fail++; $display("FAIL back_to_back got resp=%0d acks=%0d dat=%h mask=%b want 2/1/22220000/100",
            o_resp, o_nack, o_dat, o_cyc_or);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         int idx, kind, d, drop;
         logic [31:0] adr, wd, rd;
         idx  = int'($urandom % 4);
         kind = int'($urandom % 4);
         d    = int'($urandom_range(1, 10));
         adr  = $urandom;
         adr[21:20] = idx[1:0];
         wd   = $urandom;
         rd   = $urandom;
         model(idx, d, kind, rd);
         drop = ($urandom % 3 == 0) ? int'($urandom_range(1, e_resp)) : 0;
         run_txn(adr, 1'($urandom % 2), wd, 4'($urandom), d, kind, rd, drop);
         n_checks++;
         if (o_resp !== e_resp || o_nack !== int'(e_ack) || o_nerr !== int'(e_err) || o_nto !== int'(e_to)) begin
            n_fail++; $display("FAIL rand%0d_resp got resp=%0d ack=%0d err=%0d to=%0d want %0d/%0d/%0d/%0d",
               n, o_resp, o_nack, o_nerr, o_nto, e_resp, e_ack, e_err, e_to);
         end
         n_checks++;
         if (o_dat !== e_dat) begin
            n_fail++; $display("FAIL rand%0d_data got %h want %h", n, o_dat, e_dat);
         end
         n_checks++;
         if (o_ncyc !== e_ncyc || o_cyc_or !== e_cyc_or || o_shared_bad !== 0 || o_stb_bad !== 0) begin
            n_fail++; $display("FAIL rand%0d_slave got cycles=%0d mask=%b shared_bad=%0d stb_bad=%0d want %0d/%b/0/0",
               n, o_ncyc, o_cyc_or, o_shared_bad, o_stb_bad, e_ncyc, e_cyc_or);
         end
         n_checks++;
         if (o_ndrop !== ((drop != 0) ? 1 : 0) || o_nboth !== 0 || o_busy_after !== 1'b0) begin
            n_fail++; $display("FAIL rand%0d_misc got drops=%0d both=%0d busy_after=%b want %0d/0/0",
               n, o_ndrop, o_nboth, o_busy_after, (drop != 0) ? 1 : 0);
         end
      end
   endtask

   task automatic test_reset_mid_active();
      run_txn(32'h0010_0000, 1'b1, 32'hFACE_0000, 4'b0101, 1, 0, 32'hA5A5_0001, 0);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_adr_i = 32'h0010_00F0; bus.wbs_dat_i = 32'h0F0F_0F0F; bus.wbs_sel_i = 4'hF;
      bus.wbm_ack_i = '0; bus.wbm_err_i = '0;
      @(posedge clk); #1;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.wbm_cyc_o !== 3'b010 || bus.busy_o !== 1'b1) begin
         n_fail++; $display("FAIL midrst_pre got cyc=%b busy=%b want 010/1", bus.wbm_cyc_o, bus.busy_o);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.busy_o, bus.wbs_ack_o, bus.wbs_err_o, bus.timeout_o, bus.dropped_o} !== '0) begin
         n_fail++; $display("FAIL midrst_flags got cyc=%b stb=%b busy=%b ack=%b err=%b want all 0",
            bus.wbm_cyc_o, bus.wbm_stb_o, bus.busy_o, bus.wbs_ack_o, bus.wbs_err_o);
      end
      n_checks++;
      if ({bus.wbs_dat_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_we_o, bus.wbm_sel_o} !== '0) begin
         n_fail++; $display("FAIL midrst_data got dat_o=%h adr=%h wdat=%h we=%b sel=%b want 0",
            bus.wbs_dat_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_we_o, bus.wbm_sel_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_txn(32'h0000_0020, 1'b0, 32'h0, 4'hF, 1, 0, 32'h600D_CAFE, 0);
      n_checks++;
      if (o_resp !== 2 || o_nack !== 1 || o_dat !== 32'h600D_CAFE || o_ncyc !== 1) begin
         n_fail++; $display("FAIL midrst_after got resp=%0d acks=%0d dat=%h cycles=%0d want 2/1/600dcafe/1",
            o_resp, o_nack, o_dat, o_ncyc);
      end
   endtask

   initial begin
      test_reset();
      test_read_slave1();
      test_write_slave0();
      test_watchdog();
      test_ack_final_edge();
      test_invalid_index();
      test_ack_and_err();
      test_dropped();
      test_back_to_back();
      test_random();
      test_reset_mid_active();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit got still running want finished");
      $fatal(1);
   end
endmodule
